matmul_operand_feeder: RTL and testbench

//  Upstream sequencer for fp32_mult_pipelined in the matrix-multiply datapath.

---
 rtl/matmul_operand_feeder.sv | 175 +++++++++++++++++
 tb/tb_matmul_operand_feeder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_operand_feeder.sv
// matmul_operand_feeder
//   Walks C = A x B (square, row-major, dim x dim) in i/j/k order and feeds the
//   pipelined fp32 multiplier one operand pair per cycle. A[i][k] and B[k][j]
//   are fetched from two synchronous-read RAMs; the returned words are
//   registered onto a/b together with the row/col/last_k tags the accumulator
//   needs.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   go, dim                 job request (sampled in IDLE) and matrix dimension
//   hold                    back-pressure: suppress new RAM reads while high
//   a_rd_en/addr/data       A RAM read port (data valid one cycle after en)
//   b_rd_en/addr/data       B RAM read port (data valid one cycle after en)
//   start, a, b             operand pair to the multiplier, one cycle per pair
//   row, col, last_k        tags aligned with a/b
//   busy, done, err         job status; done and err are one-cycle pulses
module matmul_operand_feeder #(
  parameter int DIM_MAX = 4,
  parameter int ADDR_W  = $clog2(DIM_MAX*DIM_MAX),
  parameter int DATA_W  = 32,
  localparam int DIM_W  = $clog2(DIM_MAX+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [DIM_W-1:0]  dim,
  input  logic              hold,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [DATA_W-1:0] a_rd_data,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic              start,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              last_k,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DIM_W-1:0]  dim_reg, i_reg, j_reg, k_reg;
  logic [ADDR_W-1:0] a_base_reg;   // i*dim, kept as a running sum
  logic [ADDR_W-1:0] b_addr_reg;   // k*dim + j, kept as a running sum
  logic              v1_reg;       // stage 1: read issued last cycle
  logic [ADDR_W-1:0] row1_reg, col1_reg;
  logic              lk1_reg;
  logic              err_reg;

  logic              dim_ok, go_acc, rd_fire;
  logic              i_last, j_last, k_last, last_read;
  logic [DIM_W-1:0]  dim_last;
  logic [ADDR_W-1:0] dim_ext;

  assign dim_ok    = (dim != '0) && (int'(dim) <= DIM_MAX);
  assign go_acc    = (state_reg == IDLE) && go && dim_ok;
  assign rd_fire   = (state_reg == ISSUE) && !hold;
  assign dim_last  = dim_reg - DIM_W'(1);
  assign dim_ext   = ADDR_W'(dim_reg);
  assign i_last    = (i_reg == dim_last);
  assign j_last    = (j_reg == dim_last);
  assign k_last    = (k_reg == dim_last);
  assign last_read = rd_fire && i_last && j_last && k_last;

  assign a_rd_en   = rd_fire;
  assign b_rd_en   = rd_fire;
  assign a_rd_addr = a_base_reg + ADDR_W'(k_reg);
  assign b_rd_addr = b_addr_reg;

  assign busy = (state_reg == ISSUE) || (state_reg == DRAIN);
  assign done = (state_reg == DONE);
  assign err  = err_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (go_acc) state_next = ISSUE;
      ISSUE: if (last_read) state_next = DRAIN;
      // Only stage 1 has to be empty: the pair in stage 2 is being presented
      // this cycle, so DONE lands exactly one cycle after the final start.
      DRAIN: if (!v1_reg) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= (state_reg == IDLE) && go && !dim_ok;
    end
  end

  // Loop counters and running address bases; advance k, then j, then i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_reg    <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      a_base_reg <= '0;
      b_addr_reg <= '0;
    end else if (go_acc) begin
      dim_reg    <= dim;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      a_base_reg <= '0;
      b_addr_reg <= '0;
    end else if (rd_fire) begin
      if (k_last) begin
        k_reg <= '0;
        if (j_last) begin
          j_reg      <= '0;
          b_addr_reg <= '0;
          if (i_last) begin
            i_reg      <= '0;
            a_base_reg <= '0;
          end else begin
            i_reg      <= i_reg + DIM_W'(1);
            a_base_reg <= a_base_reg + dim_ext;
          end
        end else begin
          j_reg      <= j_reg + DIM_W'(1);
          b_addr_reg <= ADDR_W'(j_reg) + ADDR_W'(1);
        end
      end else begin
        k_reg      <= k_reg + DIM_W'(1);
        b_addr_reg <= b_addr_reg + dim_ext;
      end
    end
  end

  // Two-stage tag/valid shift: stage 1 waits for the RAM, stage 2 captures
  // the RAM data. Payload registers only load on a valid pair so they hold
  // their last value through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg   <= 1'b0;
      row1_reg <= '0;
      col1_reg <= '0;
      lk1_reg  <= 1'b0;
      start    <= 1'b0;
      a        <= '0;
      b        <= '0;
      row      <= '0;
      col      <= '0;
      last_k   <= 1'b0;
    end else begin
      v1_reg <= rd_fire;
      if (rd_fire) begin
        row1_reg <= ADDR_W'(i_reg);
        col1_reg <= ADDR_W'(j_reg);
        lk1_reg  <= k_last;
      end
      start <= v1_reg;
      if (v1_reg) begin
        a      <= a_rd_data;
        b      <= b_rd_data;
        row    <= row1_reg;
        col    <= col1_reg;
        last_k <= lk1_reg;
      end
    end
  end

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Randomized scoreboard bench for matmul_operand_feeder. Expected pairs are
// generated from the matrix definition (nested i/j/k loops over the RAM
// contents); a monitor pops and compares them whenever start is seen.
module tb_matmul_operand_feeder;
  localparam int DIM_MAX = 4;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              go, hold;
  logic [2:0]        dim;
  logic              a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
  logic [DATA_W-1:0] a_rd_data, b_rd_data;
  logic              start, last_k, busy, done, err;
  logic [DATA_W-1:0] a, b;
  logic [ADDR_W-1:0] row, col;

  matmul_operand_feeder #(.DIM_MAX(DIM_MAX), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .dim(dim), .hold(hold),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .start(start), .a(a), .b(b), .row(row), .col(col), .last_k(last_k),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] a_mem [16];
  logic [DATA_W-1:0] b_mem [16];

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  typedef struct {
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    int                er;
    int                ec;
    bit                elk;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0, first_rd = -1, first_st = -1;
  int n_start = 0, n_lk = 0, n_done = 0, n_err = 0;
  int gaps = 0, zrun = 0;
  bit seen = 0, prev_start = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (a_rd_en && first_rd < 0) first_rd = cyc;
      checks++;
      if (a_rd_en !== b_rd_en || (hold && a_rd_en)) begin
        errors++;
        $display("FAIL rd_en: a_rd_en=%0b b_rd_en=%0b hold=%0b", a_rd_en, b_rd_en, hold);
      end
      if (start) begin
        if (first_st < 0) first_st = cyc;
        if (seen) gaps += zrun;
        zrun = 0;
        seen = 1;
        n_start++;
        if (last_k) n_lk++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pair: unexpected start a=%h b=%h row=%0d col=%0d", a, b, row, col);
        end else begin
          e = sb.pop_front();
          if (a !== e.ea || b !== e.eb || int'(row) != e.er || int'(col) != e.ec || last_k !== e.elk) begin
            errors++;
            $display("FAIL pair: got a=%h b=%h r=%0d c=%0d lk=%0b expected a=%h b=%h r=%0d c=%0d lk=%0b",
                     a, b, row, col, last_k, e.ea, e.eb, e.er, e.ec, e.elk);
          end
        end
      end else if (seen) begin
        zrun++;
      end
      if (done) begin
        n_done++;
        checks++;
        if (!prev_start || busy) begin
          errors++;
          $display("FAIL done_timing: prev_start=%0b busy=%0b expected 1 and 0", prev_start, busy);
        end
      end
      if (err) n_err++;
      prev_start = start;
    end else begin
      prev_start = 0;
    end
  end

  task automatic push_expected(input int d);
    exp_t e;
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++)
        for (int k = 0; k < d; k++) begin
          e.ea  = a_mem[i*d + k];
          e.eb  = b_mem[k*d + j];
          e.er  = i;
          e.ec  = j;
          e.elk = (k == d-1);
          sb.push_back(e);
        end
  endtask

  task automatic fill_random();
    for (int n = 0; n < 16; n++) begin
      a_mem[n] = $urandom;
      b_mem[n] = $urandom;
    end
  endtask

  // hold_len < 0 with rand_hold=0 means no hold at all.
  task automatic run_job(input int d, input int hold_at, input int hold_len,
                         input bit rand_hold, input bit extra_go);
    int  done0, err0;
    bit  got;
    push_expected(d);
    n_start = 0; n_lk = 0; seen = 0; gaps = 0; zrun = 0;
    first_rd = -1; first_st = -1;
    done0 = n_done; err0 = n_err;
    @(posedge clk); #1;
    go = 1'b1; dim = 3'(d);
    got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge clk); #1;
      go = extra_go && (c == 2);
      if (rand_hold) hold = ($urandom_range(0, 3) == 0);
      else           hold = (c >= hold_at) && (c < hold_at + hold_len);
      if (done) got = 1;
    end
    hold = 1'b0;
    go   = 1'b0;
    @(negedge clk); #1;
    chk("done_seen", int'(got), 1);
    chk("start_count", n_start, d*d*d);
    chk("last_k_count", n_lk, d*d);
    chk("done_count", n_done - done0, 1);
    chk("err_during_job", n_err - err0, 0);
    chk("sb_empty", sb.size(), 0);
    chk("latency", first_st - first_rd, 2);
    if (!rand_hold) chk("start_gaps", gaps, (hold_len > 0) ? hold_len : 0);
    chk("busy_after", int'(busy), 0);
    $display("job dim=%0d hold_len=%0d rand_hold=%0b extra_go=%0b starts=%0d", d, hold_len, rand_hold, extra_go, n_start);
  endtask

  task automatic bad_go(input int d);
    @(posedge clk); #1;
    go = 1'b1; dim = 3'(d);
    @(posedge clk); #1;
    go = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    chk("err_rd_en", int'(a_rd_en), 0);
    @(posedge clk); #1;
    chk("err_clear", int'(err), 0);
    chk("err_idle_busy", int'(busy), 0);
    $display("illegal go dim=%0d", d);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_rd_en"}, int'(a_rd_en | b_rd_en), 0);
    chk({tag, "_ab"}, int'(|{a, b}), 0);
    chk({tag, "_tags"}, int'(|{row, col, last_k}), 0);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; hold = 1'b0; dim = '0;
    fill_random();
    #1;
    chk_outputs_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // 1: known matrices, dim=2, no hold
    a_mem[0] = 32'h3F800000; a_mem[1] = 32'h40000000; a_mem[2] = 32'h40400000; a_mem[3] = 32'h40800000;
    b_mem[0] = 32'h40A00000; b_mem[1] = 32'h40C00000; b_mem[2] = 32'h40E00000; b_mem[3] = 32'h41000000;
    run_job(2, 0, -1, 0, 0);

    // 2: dim=1
    fill_random();
    run_job(1, 0, -1, 0, 0);

    // 3: dim=2, 3-cycle hold mid-job
    fill_random();
    run_job(2, 3, 3, 0, 0);

    // 4: illegal dimensions
    bad_go(0);
    bad_go(5);

    // 5: go while busy is ignored
    fill_random();
    run_job(3, 0, -1, 0, 1);

    // random jobs with random back-pressure
    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_job(int'($urandom_range(1, DIM_MAX)), 0, -1, 1, 0);
    end

    // 6: asynchronous reset mid-ISSUE, then a clean restart
    fill_random();
    push_expected(4);
    @(posedge clk); #1;
    go = 1'b1; dim = 3'd4;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    $display("reset mid-job dim=4");
    fill_random();
    run_job(2, 0, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
